// File: rtl/vlsu_axi_mem_responder.sv
// vlsu_axi_mem_responder
//
// AXI4 slave that terminates the VLSU master port and backs it with a flat,
// byte-addressed on-chip memory. Independent read and write engines each
// handle one burst at a time.
//
// Handshake rule (all five channels): a beat transfers on a rising clk_i edge
// where valid and ready are both 1. A source holds valid and every payload
// field stable until that edge, and never waits for ready before raising valid.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ar_*                         read request (id/addr/len/size/burst)
//   r_*                          read data beats (id/data/resp/last)
//   aw_*                         write request (id/addr/len/size/burst)
//   w_*                          write data beats (data/strb/last)
//   b_*                          write response (id/resp)
//   dbg_r_state_o, dbg_w_state_o current state of the read / write FSM
//
// Bursts other than INCR/FIXED, a size that is not the full bus width, or a
// beat address beyond the memory return SLVERR; the burst still runs to its
// full length, errored read beats carry zero data and errored write beats are
// dropped. Memory contents are not reset.
module vlsu_axi_mem_responder #(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned MemBytes     = 4096,
  parameter int unsigned ReadLatency  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AxiIdWidth-1:0]     ar_id_i,
  input  logic [AxiAddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AxiIdWidth-1:0]     r_id_o,
  output logic [AxiDataWidth-1:0]   r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AxiIdWidth-1:0]     aw_id_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic [1:0]                aw_burst_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AxiIdWidth-1:0]     b_id_o,
  output logic [1:0]                b_resp_o,
  output logic [1:0]                dbg_r_state_o,
  output logic [1:0]                dbg_w_state_o
);

  localparam int unsigned StrbW = AxiDataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned Words = MemBytes / StrbW;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned LatW  = $clog2(ReadLatency + 1);

  localparam logic [AxiAddrWidth-1:0] MemLimit = AxiAddrWidth'(MemBytes);
  localparam logic [AxiAddrWidth-1:0] BeatStep = AxiAddrWidth'(StrbW);
  localparam logic [2:0]              SizeOk   = 3'(OffW);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

  logic [AxiDataWidth-1:0] mem_q [Words];

  // Readies stay low until the first clock edge after reset release.
  logic out_en_q;

  // ---------------------------------------------------------------- read side
  r_state_e                r_state_q, r_state_d;
  logic [AxiIdWidth-1:0]   r_id_q;
  logic [AxiAddrWidth-1:0] r_addr_q;
  logic [7:0]              r_len_q, r_beat_q;
  logic                    r_bad_q, r_fixed_q;
  logic [LatW-1:0]         r_lat_q;
  logic [AxiDataWidth-1:0] r_data_q;
  logic [1:0]              r_resp_q;

  logic                    ar_hs, r_hs, r_last;
  logic [AxiAddrWidth-1:0] ar_aligned;
  logic                    ar_bad;
  logic [AxiAddrWidth-1:0] rd_fetch_addr;
  logic                    rd_fetch_bad, rd_fetch_err, rd_load;
  logic [AxiDataWidth-1:0] rd_fetch_data;

  assign ar_hs      = ar_valid_i & ar_ready_o;
  assign r_hs       = r_valid_o & r_ready_i;
  assign r_last     = (r_beat_q == r_len_q);
  assign ar_aligned = {ar_addr_i[AxiAddrWidth-1:OffW], {OffW{1'b0}}};
  assign ar_bad     = ((ar_burst_i != BurstIncr) && (ar_burst_i != BurstFixed)) ||
                      (ar_size_i != SizeOk);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = (ReadLatency == 1) ? R_BURST : R_WAIT;
      R_WAIT:  if (r_lat_q == LatW'(1)) r_state_d = R_BURST;
      R_BURST: if (r_hs && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready_o    = out_en_q && (r_state_q == R_IDLE);
    r_valid_o     = (r_state_q == R_BURST);
    r_last_o      = (r_state_q == R_BURST) && r_last;
    r_id_o        = r_id_q;
    r_data_o      = r_data_q;
    r_resp_o      = r_resp_q;
    dbg_r_state_o = r_state_q;
  end

  // The presented beat lives in registers so it holds under backpressure even
  // if the write engine updates the same word while the beat is stalled.
  // A beat is fetched when the wait expires and after every non-last handshake.
  always_comb begin
    rd_fetch_addr = r_addr_q;
    rd_fetch_bad  = r_bad_q;
    rd_load       = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        rd_fetch_addr = ar_aligned;
        rd_fetch_bad  = ar_bad;
        rd_load       = ar_hs && (ReadLatency == 1);
      end
      R_WAIT:  rd_load = (r_lat_q == LatW'(1));
      R_BURST: begin
        rd_fetch_addr = r_fixed_q ? r_addr_q : r_addr_q + BeatStep;
        rd_load       = r_hs && !r_last;
      end
      default: rd_load = 1'b0;
    endcase
    rd_fetch_err  = rd_fetch_bad || (rd_fetch_addr >= MemLimit);
    rd_fetch_data = rd_fetch_err ? '0 : mem_q[rd_fetch_addr[OffW +: IdxW]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_en_q  <= 1'b0;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_bad_q   <= 1'b0;
      r_fixed_q <= 1'b0;
      r_lat_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
    end else begin
      out_en_q <= 1'b1;
      if (ar_hs) begin
        r_id_q    <= ar_id_i;
        r_addr_q  <= ar_aligned;
        r_len_q   <= ar_len_i;
        r_beat_q  <= '0;
        r_bad_q   <= ar_bad;
        r_fixed_q <= (ar_burst_i == BurstFixed);
        r_lat_q   <= LatW'(ReadLatency - 1);
      end else if (r_state_q == R_WAIT) begin
        r_lat_q <= r_lat_q - LatW'(1);
      end
      if (r_state_q == R_BURST && r_hs && !r_last) begin
        r_beat_q <= r_beat_q + 8'd1;
        r_addr_q <= rd_fetch_addr;
      end
      if (rd_load) begin
        r_data_q <= rd_fetch_data;
        r_resp_q <= rd_fetch_err ? RespSlvErr : RespOkay;
      end
    end
  end

  // --------------------------------------------------------------- write side
  w_state_e                w_state_q, w_state_d;
  logic [AxiIdWidth-1:0]   w_id_q;
  logic [AxiAddrWidth-1:0] w_addr_q;
  logic [7:0]              w_len_q, w_beat_q;
  logic                    w_bad_q, w_fixed_q;
  logic                    w_past_q;  // beat aw_len accepted without w_last
  logic                    w_err_q;

  logic                    aw_hs, w_hs, b_hs;
  logic [AxiAddrWidth-1:0] aw_aligned;
  logic                    aw_bad;
  logic                    wr_beat_err, wr_len_err, wr_en;
  logic [IdxW-1:0]         wr_idx;

  assign aw_hs       = aw_valid_i & aw_ready_o;
  assign w_hs        = w_valid_i & w_ready_o;
  assign b_hs        = b_valid_o & b_ready_i;
  assign aw_aligned  = {aw_addr_i[AxiAddrWidth-1:OffW], {OffW{1'b0}}};
  assign aw_bad      = ((aw_burst_i != BurstIncr) && (aw_burst_i != BurstFixed)) ||
                       (aw_size_i != SizeOk);
  assign wr_beat_err = w_bad_q || (w_addr_q >= MemLimit) || w_past_q;
  assign wr_len_err  = w_last_i && (w_past_q || (w_beat_q != w_len_q));
  assign wr_en       = w_hs && !wr_beat_err;
  assign wr_idx      = w_addr_q[OffW +: IdxW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_i) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o    = out_en_q && (w_state_q == W_IDLE);
    w_ready_o     = (w_state_q == W_DATA);
    b_valid_o     = (w_state_q == W_RESP);
    b_id_o        = w_id_q;
    b_resp_o      = ((w_state_q == W_RESP) && w_err_q) ? RespSlvErr : RespOkay;
    dbg_w_state_o = w_state_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_bad_q   <= 1'b0;
      w_fixed_q <= 1'b0;
      w_past_q  <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id_q    <= aw_id_i;
        w_addr_q  <= aw_aligned;
        w_len_q   <= aw_len_i;
        w_beat_q  <= '0;
        w_bad_q   <= aw_bad;
        w_fixed_q <= (aw_burst_i == BurstFixed);
        w_past_q  <= 1'b0;
        w_err_q   <= 1'b0;
      end else if (w_hs) begin
        w_err_q <= w_err_q | wr_beat_err | wr_len_err;
        // Once the declared length is used up the counter parks and every
        // further beat is treated as overrun.
        if (w_beat_q == w_len_q) begin
          w_past_q <= 1'b1;
        end else begin
          w_beat_q <= w_beat_q + 8'd1;
          if (!w_fixed_q) w_addr_q <= w_addr_q + BeatStep;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb_i[b]) mem_q[wr_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // Sub-word address bits never select anything on a full-width bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ar_addr_i[OffW-1:0], aw_addr_i[OffW-1:0]};

endmodule
